// File: rtl/osd_spi_cmd_seq.sv
// Command sequencer behind the OSD SPI byte slave: decodes the first byte of each
// transaction, streams buffer writes, holds OSD control. Optional feature macro: OSD_CHECKSUM_EN.
module osd_spi_cmd_seq #(
    parameter int         ROW_W   = 3,
    parameter int         COL_W   = 8,
    parameter logic [7:0] VERSION = 8'h12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk7_en,
    input  logic                   rx,
    input  logic                   cmd,
    input  logic                   vld,
    input  logic [7:0]             rx_data,
    output logic [7:0]             spi_in,
    output logic                   wr_en,
    output logic [ROW_W+COL_W-1:0] wr_addr,
    output logic [7:0]             wr_data,
    output logic                   osd_enable,
    output logic [3:0]             hl_row,
    output logic                   busy
);
    typedef enum logic [2:0] {IDLE, WR_BUF, SET_HL, RD_STAT, RD_TAIL, RD_SUM, DISCARD} state_t;

    state_t                 state, state_nxt;
    logic                   rx_d, rx_d_nxt;
    logic                   armed, armed_nxt;
    logic                   ev;
    logic [ROW_W-1:0]       row, row_nxt;
    logic [COL_W-1:0]       col, col_nxt;
    logic [7:0]             spi_nxt, wr_data_nxt;
    logic                   wr_en_nxt, osd_en_nxt;
    logic [ROW_W+COL_W-1:0] wr_addr_nxt;
    logic [3:0]             hl_nxt;
`ifdef OSD_CHECKSUM_EN
    logic [7:0]             acc, acc_nxt;
`endif

    // armed stays low after reset until rx is seen low, so a byte strobe that
    // straddles reset release is never taken as a fresh byte
    assign ev   = clk7_en & rx & ~rx_d & armed;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rx_d       <= 1'b0;
            armed      <= 1'b0;
            row        <= '0;
            col        <= '0;
            spi_in     <= 8'h00;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            osd_enable <= 1'b0;
            hl_row     <= 4'hF;
`ifdef OSD_CHECKSUM_EN
            acc        <= 8'h00;
`endif
        end else begin
            state      <= state_nxt;
            rx_d       <= rx_d_nxt;
            armed      <= armed_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            spi_in     <= spi_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            osd_enable <= osd_en_nxt;
            hl_row     <= hl_nxt;
`ifdef OSD_CHECKSUM_EN
            acc        <= acc_nxt;
`endif
        end
    end

    // wr_en defaults low every clk so the write strobe is a single clk wide
    always_comb begin
        state_nxt   = state;
        rx_d_nxt    = rx_d;
        armed_nxt   = armed;
        row_nxt     = row;
        col_nxt     = col;
        spi_nxt     = spi_in;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        osd_en_nxt  = osd_enable;
        hl_nxt      = hl_row;
`ifdef OSD_CHECKSUM_EN
        acc_nxt     = acc;
`endif
        if (clk7_en) begin
            rx_d_nxt = rx;
            if (!rx)
                armed_nxt = 1'b1;
            if (ev && cmd) begin
                if (rx_data[7:3] == 5'b00100) begin
                    state_nxt = WR_BUF;
                    row_nxt   = ROW_W'(rx_data[2:0]);
                    col_nxt   = '0;
`ifdef OSD_CHECKSUM_EN
                    acc_nxt   = 8'h00;
`endif
                end else begin
                    case (rx_data)
                        8'h40: begin
                            osd_en_nxt = 1'b0;
                            state_nxt  = IDLE;
                        end
                        8'h41: begin
                            osd_en_nxt = 1'b1;
                            state_nxt  = IDLE;
                        end
                        8'h60: state_nxt = SET_HL;
                        8'h80: begin
                            state_nxt = RD_STAT;
                            spi_nxt   = {6'b0, osd_enable, 1'b1};
                        end
`ifdef OSD_CHECKSUM_EN
                        8'h81: begin
                            state_nxt = RD_SUM;
                            spi_nxt   = acc;
                        end
`endif
                        default: state_nxt = DISCARD;
                    endcase
                end
            end else if (ev) begin
                case (state)
                    WR_BUF: begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = {row, col};
                        wr_data_nxt = rx_data;
                        col_nxt     = col + COL_W'(1);
`ifdef OSD_CHECKSUM_EN
                        acc_nxt     = acc ^ rx_data;
`endif
                    end
                    SET_HL: begin
                        hl_nxt    = rx_data[3:0];
                        state_nxt = DISCARD;
                    end
                    RD_STAT: begin
                        spi_nxt   = VERSION;
                        state_nxt = RD_TAIL;
                    end
                    RD_TAIL: spi_nxt = 8'h00;
`ifdef OSD_CHECKSUM_EN
                    RD_SUM:  spi_nxt = acc;
`endif
                    default: ;
                endcase
            end else if (!vld) begin
                state_nxt = IDLE;
                spi_nxt   = 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_osd_spi_cmd_seq.sv
// Bench for osd_spi_cmd_seq: directed plus randomized transactions checked against a
// transaction-level model of the command set (OSD_CHECKSUM_EN aware).
module tb_osd_spi_cmd_seq;
    localparam logic [7:0] VERSION = 8'h12;
    localparam int M_IDLE = 0, M_WR = 1, M_HL = 2, M_STAT = 3, M_SUM = 4, M_DISC = 5;
`ifdef OSD_CHECKSUM_EN
    localparam logic [7:0] EXP_SUM = 8'hFE;
`else
    localparam logic [7:0] EXP_SUM = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset, clk7_en, rx, cmd, vld;
    logic [7:0]  rx_data;
    logic [7:0]  spi_in, wr_data;
    logic        wr_en, osd_enable, busy;
    logic [10:0] wr_addr;
    logic [3:0]  hl_row;

    int vectors = 0, miscompares = 0, we_cycles = 0;

    int          m_mode, m_row, m_col, m_reads, m_writes;
    logic [7:0]  m_spi, m_wdata, m_acc;
    logic [10:0] m_addr;
    logic        m_osd;
    logic [3:0]  m_hl;

    osd_spi_cmd_seq #(.ROW_W(3), .COL_W(8), .VERSION(VERSION)) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .rx(rx), .cmd(cmd), .vld(vld),
        .rx_data(rx_data), .spi_in(spi_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .osd_enable(osd_enable), .hl_row(hl_row), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) we_cycles++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run did not complete, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".spi_in"}, 32'(spi_in), 32'(m_spi));
        check({tag, ".osd_enable"}, 32'(osd_enable), 32'(m_osd));
        check({tag, ".hl_row"}, 32'(hl_row), 32'(m_hl));
        check({tag, ".busy"}, 32'(busy), 32'(m_mode != M_IDLE));
        check({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_addr));
        check({tag, ".wr_data"}, 32'(wr_data), 32'(m_wdata));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_spi = 8'h00; m_osd = 1'b0; m_hl = 4'hF;
        m_row = 0; m_col = 0; m_reads = 0; m_acc = 8'h00; m_addr = '0; m_wdata = 8'h00;
    endtask

    task automatic model_cmd(input logic [7:0] d);
        if (d[7:3] == 5'b00100) begin
            m_mode = M_WR; m_row = int'(d[2:0]); m_col = 0; m_acc = 8'h00;
        end else if (d == 8'h40) begin
            m_osd = 1'b0; m_mode = M_IDLE;
        end else if (d == 8'h41) begin
            m_osd = 1'b1; m_mode = M_IDLE;
        end else if (d == 8'h60) begin
            m_mode = M_HL;
        end else if (d == 8'h80) begin
            m_mode = M_STAT; m_reads = 0; m_spi = m_osd ? 8'h03 : 8'h01;
`ifdef OSD_CHECKSUM_EN
        end else if (d == 8'h81) begin
            m_mode = M_SUM; m_spi = m_acc;
`endif
        end else begin
            m_mode = M_DISC;
        end
    endtask

    task automatic model_data(input logic [7:0] d, output bit we);
        we = 1'b0;
        case (m_mode)
            M_WR: begin
                we = 1'b1;
                m_addr = 11'(m_row * 256 + m_col);
                m_wdata = d;
                m_col = (m_col + 1) % 256;
                m_acc = m_acc ^ d;
                m_writes++;
            end
            M_HL: begin m_hl = d[3:0]; m_mode = M_DISC; end
            M_STAT: begin m_spi = (m_reads == 0) ? VERSION : 8'h00; m_reads++; end
            M_SUM: m_spi = m_acc;
            default: ;
        endcase
    endtask

    // returns at a falling edge whose following rising edge has clk7_en=1
    task automatic en_tick();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            clk7_en = ($urandom_range(0, 2) != 0);
            if (clk7_en) return;
        end
        clk7_en = 1'b1;
    endtask

    task automatic send_byte(input bit c, input logic [7:0] d, input int hold);
        bit exp_we;
        en_tick();
        rx = 1'b1; cmd = c; rx_data = d;
        exp_we = 1'b0;
        if (c) model_cmd(d);
        else   model_data(d, exp_we);
        @(posedge clk); #1;
        check("wr_en", 32'(wr_en), 32'(exp_we));
        check_outputs("byte");
        for (int i = 1; i < hold; i++) en_tick();
        en_tick();
        rx = 1'b0; cmd = 1'($urandom); rx_data = 8'($urandom);
        en_tick();
    endtask

    task automatic end_txn();
        en_tick();
        vld = 1'b0;
        @(posedge clk); #1;
        m_mode = M_IDLE; m_spi = 8'h00;
        check_outputs("vld_low");
        #2;
        check("wr_pulses", 32'(we_cycles), 32'(m_writes));
        en_tick();
        vld = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check("rst.wr_en", 32'(wr_en), 32'(0));
        check_outputs("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) en_tick();
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b0; rx = 1'b0; cmd = 1'b0; vld = 1'b0; rx_data = 8'h00;
        m_writes = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("init.wr_en", 32'(wr_en), 32'(0));
        check_outputs("init");
        reset = 1'b0;
        repeat (2) en_tick();
        vld = 1'b1;

        // basic write stream into row 2
        send_byte(1, 8'h22, 1);
        send_byte(0, 8'hA5, 1);
        check("wr200.addr", 32'(wr_addr), 32'h200);
        send_byte(0, 8'h5A, 2);
        check("wr201.addr", 32'(wr_addr), 32'h201);
        check("busy_held", 32'(busy), 32'(1));
        end_txn();

        // column wrap in row 7
        send_byte(1, 8'h27, 1);
        for (int i = 0; i < 257; i++) send_byte(0, 8'($urandom), $urandom_range(1, 2));
        check("wrap_addr", 32'(wr_addr), 32'h700);
        end_txn();

        // enable, then status read
        send_byte(1, 8'h41, 1);
        end_txn();
        send_byte(1, 8'h80, 1);
        check("stat0", 32'(spi_in), 32'h03);
        send_byte(0, 8'($urandom), 1);
        check("stat1", 32'(spi_in), 32'h12);
        send_byte(0, 8'($urandom), 1);
        check("stat2", 32'(spi_in), 32'h00);
        end_txn();

        // highlight, then unknown command
        send_byte(1, 8'h60, 1);
        send_byte(0, 8'hF3, 1);
        send_byte(0, 8'h07, 1);
        check("hl3", 32'(hl_row), 32'h3);
        send_byte(1, 8'hC5, 1);
        send_byte(0, 8'($urandom), 1);
        end_txn();

        // long rx hold, then reset between data bytes
        send_byte(1, 8'h21, 1);
        send_byte(0, 8'h3C, 3);
        send_byte(0, 8'hC3, 3);
        do_reset();
        vld = 1'b1;
        send_byte(0, 8'h99, 1);
        end_txn();

        // byte strobe pending across reset release
        en_tick();
        rx = 1'b1; cmd = 1'b1; rx_data = 8'h41;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) en_tick();
        @(posedge clk); #1;
        check_outputs("pending_rx");
        en_tick(); rx = 1'b0;
        repeat (2) en_tick();

        // checksum readback
        send_byte(1, 8'h20, 1);
        send_byte(0, 8'h0F, 1);
        send_byte(0, 8'hF1, 1);
        end_txn();
        send_byte(1, 8'h81, 1);
        check("csum", 32'(spi_in), 32'(EXP_SUM));
        send_byte(0, 8'($urandom), 1);
        end_txn();

        // randomized transactions, including mid-transaction command aborts
        for (int t = 0; t < 30; t++) begin
            for (int b = 0; b < int'($urandom_range(1, 6)); b++) begin
                logic [7:0] c;
                case ($urandom_range(0, 9))
                    0, 1, 2, 9: c = 8'h20 | 8'($urandom_range(0, 7));
                    3: c = 8'h40;
                    4: c = 8'h41;
                    5: c = 8'h60;
                    6: c = 8'h80;
                    7: c = 8'h81;
                    default: c = 8'($urandom);
                endcase
                if (b == 0 || $urandom_range(0, 7) == 0) send_byte(1, c, $urandom_range(1, 3));
                else send_byte(0, 8'($urandom), $urandom_range(1, 3));
            end
            end_txn();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
